// File: rtl/enc_velocity.sv
// Encoder velocity estimator: windowed position delta, 4-deep running mean,
// stall detection and a sticky decoder-fault flag.
module enc_velocity #(
   parameter int unsigned STALL_WINDOWS = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] count,
   input  logic        faultn,
   input  logic        enable,
   input  logic [23:0] window,
   input  logic        clear_fault,
   output logic [31:0] velocity,
   output logic [31:0] vel_avg,
   output logic        vel_valid,
   output logic        avg_full,
   output logic        stalled,
   output logic        fault_latched
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;
   localparam logic [7:0] STALL_LIM = 8'(STALL_WINDOWS);

   logic [0:0]  state_reg;
   logic [23:0] timer_reg;
   logic [31:0] last_reg;
   logic [31:0] hist_reg [4];
   logic [2:0]  fill_reg;
   logic [7:0]  stall_cnt_reg;
   logic        bad_reg;
   logic [31:0] vel_reg;
   logic [31:0] avg_reg;
   logic        valid_reg;
   logic        stalled_reg;
   logic        fault_reg;

   logic [23:0] reload;
   logic [31:0] delta;
   logic [33:0] sum;
   logic [7:0]  stall_next;
   logic        good_window;

   // window=0 behaves as a one-cycle window
   assign reload      = (window == 24'd0) ? 24'd0 : window - 24'd1;
   assign delta       = count - last_reg;
   assign sum         = {{2{delta[31]}}, delta}
                      + {{2{hist_reg[0][31]}}, hist_reg[0]}
                      + {{2{hist_reg[1][31]}}, hist_reg[1]}
                      + {{2{hist_reg[2][31]}}, hist_reg[2]};
   assign stall_next  = (stall_cnt_reg == 8'd255) ? 8'd255 : stall_cnt_reg + 8'd1;
   assign good_window = faultn && !bad_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg     <= IDLE;
         timer_reg     <= 24'd0;
         last_reg      <= 32'd0;
         fill_reg      <= 3'd0;
         stall_cnt_reg <= 8'd0;
         bad_reg       <= 1'b0;
         vel_reg       <= 32'd0;
         avg_reg       <= 32'd0;
         valid_reg     <= 1'b0;
         stalled_reg   <= 1'b0;
         fault_reg     <= 1'b0;
         for (int i = 0; i < 4; i++) hist_reg[i] <= 32'd0;
      end else begin
         valid_reg <= 1'b0;
         if (!faultn)
            fault_reg <= 1'b1;
         else if (clear_fault)
            fault_reg <= 1'b0;

         case (state_reg)
            IDLE: begin
               if (enable) begin
                  state_reg     <= RUN;
                  last_reg      <= count;
                  timer_reg     <= reload;
                  bad_reg       <= 1'b0;
                  fill_reg      <= 3'd0;
                  stall_cnt_reg <= 8'd0;
                  for (int i = 0; i < 4; i++) hist_reg[i] <= 32'd0;
               end
            end
            default: begin
               if (!enable) begin
                  state_reg <= IDLE;
               end else if (timer_reg == 24'd0) begin
                  last_reg  <= count;
                  timer_reg <= reload;
                  bad_reg   <= 1'b0;
                  if (good_window) begin
                     valid_reg <= 1'b1;
                     vel_reg   <= delta;
                     avg_reg   <= sum[33:2];
                     hist_reg[0] <= delta;
                     for (int i = 1; i < 4; i++) hist_reg[i] <= hist_reg[i-1];
                     if (fill_reg != 3'd4) fill_reg <= fill_reg + 3'd1;
                     if (delta == 32'd0) begin
                        stall_cnt_reg <= stall_next;
                        stalled_reg   <= (stall_next >= STALL_LIM);
                     end else begin
                        stall_cnt_reg <= 8'd0;
                        stalled_reg   <= 1'b0;
                     end
                  end
               end else begin
                  timer_reg <= timer_reg - 24'd1;
                  if (!faultn) bad_reg <= 1'b1;
               end
            end
         endcase
      end
   end

   assign velocity      = vel_reg;
   assign vel_avg       = avg_reg;
   assign vel_valid     = valid_reg;
   assign avg_full      = (fill_reg == 3'd4);
   assign stalled       = stalled_reg;
   assign fault_latched = fault_reg;

endmodule

// File: tb/tb_enc_velocity.sv
// Directed self-checking bench for enc_velocity.
module tb_enc_velocity;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] count;
   logic        faultn;
   logic        enable;
   logic [23:0] window;
   logic        clear_fault;
   logic [31:0] velocity;
   logic [31:0] vel_avg;
   logic        vel_valid;
   logic        avg_full;
   logic        stalled;
   logic        fault_latched;

   int checks = 0;
   int errors = 0;
   int n;
   bit got;

   enc_velocity #(.STALL_WINDOWS(4)) dut (
      .clk(clk), .reset(reset), .count(count), .faultn(faultn),
      .enable(enable), .window(window), .clear_fault(clear_fault),
      .velocity(velocity), .vel_avg(vel_avg), .vel_valid(vel_valid),
      .avg_full(avg_full), .stalled(stalled), .fault_latched(fault_latched)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
      $display("check %-18s observed %0h expected %0h", tag, obs, exp);
   endtask

   // Step cycles until vel_valid is seen or the budget runs out.
   task automatic wait_valid(input int budget, input int inc, input int fault_at,
                             input bit cf, output int cnt, output bit seen);
      cnt  = 0;
      seen = 1'b0;
      while (cnt < budget && !seen) begin
         count       = count + 32'(inc);
         faultn      = (cnt + 1 == fault_at) ? 1'b0 : 1'b1;
         clear_fault = (cnt + 1 == fault_at) ? cf : 1'b0;
         tick();
         cnt++;
         seen = vel_valid;
      end
      faultn      = 1'b1;
      clear_fault = 1'b0;
   endtask

   initial begin
      reset = 1'b1; count = 32'd100; faultn = 1'b1; enable = 1'b0;
      window = 24'd10; clear_fault = 1'b0;
      repeat (2) tick();
      chk("rst_velocity", velocity, 32'd0);
      chk("rst_vel_avg", vel_avg, 32'd0);
      chk("rst_valid", {31'd0, vel_valid}, 32'd0);
      chk("rst_flags", {29'd0, avg_full, stalled, fault_latched}, 32'd0);
      reset = 1'b0;
      tick();

      // +3 per cycle, window 10
      enable = 1'b1;
      tick();
      wait_valid(20, 3, 0, 0, n, got);
      chk("w1_period", 32'(n), 32'd10);
      chk("w1_vel", velocity, 32'd30);
      chk("w1_avg", vel_avg, 32'd7);
      chk("w1_full", {31'd0, avg_full}, 32'd0);
      wait_valid(20, 3, 0, 0, n, got);
      chk("w2_period", 32'(n), 32'd10);
      chk("w2_avg", vel_avg, 32'd15);
      wait_valid(20, 3, 0, 0, n, got);
      chk("w3_avg", vel_avg, 32'd22);
      wait_valid(20, 3, 0, 0, n, got);
      chk("w4_vel", velocity, 32'd30);
      chk("w4_avg", vel_avg, 32'd30);
      chk("w4_full", {31'd0, avg_full}, 32'd1);

      // stall: constant count
      for (int i = 1; i <= 4; i++) begin
         wait_valid(20, 0, 0, 0, n, got);
         chk("stall_period", 32'(n), 32'd10);
         chk("stall_flag", {31'd0, stalled}, (i == 4) ? 32'd1 : 32'd0);
      end
      count = count + 32'd1;
      wait_valid(20, 0, 0, 0, n, got);
      chk("unstall_vel", velocity, 32'd1);
      chk("unstall_flag", {31'd0, stalled}, 32'd0);

      // RUN->IDLE holds outputs
      enable = 1'b0;
      tick();
      chk("idle_hold_vel", velocity, 32'd1);
      chk("idle_hold_full", {31'd0, avg_full}, 32'd1);

      // wrap across 0x7FFFFFFF
      count = 32'h7FFF_FFF0;
      enable = 1'b1;
      tick();
      chk("entry_full_clr", {31'd0, avg_full}, 32'd0);
      count = count + 32'h20;
      wait_valid(20, 0, 0, 0, n, got);
      chk("wrap_got", {31'd0, got}, 32'd1);
      chk("wrap_vel", velocity, 32'h20);
      for (int i = 1; i <= 4; i++) begin
         count = count - 32'd5;
         wait_valid(20, 0, 0, 0, n, got);
         chk("neg_vel", velocity, 32'hFFFF_FFFB);
         if (i == 1) chk("neg_avg1", vel_avg, 32'd6);
      end
      chk("neg_avg4", vel_avg, 32'hFFFF_FFFB);
      chk("neg_full", {31'd0, avg_full}, 32'd1);

      // fault mid-window with simultaneous clear
      count = count + 32'd7;
      wait_valid(10, 0, 5, 1, n, got);
      chk("fault_novalid", {31'd0, got}, 32'd0);
      chk("fault_latch", {31'd0, fault_latched}, 32'd1);
      count = count - 32'd5;
      wait_valid(20, 0, 0, 0, n, got);
      chk("post_fault_period", 32'(n), 32'd10);
      chk("post_fault_avg", vel_avg, 32'hFFFF_FFFB);
      clear_fault = 1'b1;
      tick();
      clear_fault = 1'b0;
      chk("fault_clear", {31'd0, fault_latched}, 32'd0);

      // enable dropped on the expiry cycle
      enable = 1'b0;
      tick();
      enable = 1'b1;
      tick();
      wait_valid(9, 1, 0, 0, n, got);
      chk("pre_exp_novalid", {31'd0, got}, 32'd0);
      enable = 1'b0;
      count  = count + 32'd1;
      tick();
      chk("drop_novalid", {31'd0, vel_valid}, 32'd0);
      tick();
      chk("drop_novalid2", {31'd0, vel_valid}, 32'd0);
      chk("drop_vel_hold", velocity, 32'hFFFF_FFFB);

      // window changed mid-window
      enable = 1'b1;
      tick();
      window = 24'd20;
      wait_valid(40, 2, 0, 0, n, got);
      chk("win_old_period", 32'(n), 32'd10);
      chk("win_old_vel", velocity, 32'd20);
      wait_valid(40, 2, 0, 0, n, got);
      chk("win_new_period", 32'(n), 32'd20);
      chk("win_new_vel", velocity, 32'd40);

      // reset mid-window
      count  = count + 32'd3;
      faultn = 1'b0;
      tick();
      faultn = 1'b1;
      tick();
      reset = 1'b1;
      #1;
      chk("mrst_velocity", velocity, 32'd0);
      chk("mrst_vel_avg", vel_avg, 32'd0);
      chk("mrst_flags", {28'd0, vel_valid, avg_full, stalled, fault_latched}, 32'd0);
      tick();
      reset = 1'b0;
      tick();
      wait_valid(40, 1, 0, 0, n, got);
      chk("mrst_period", 32'(n), 32'd20);
      chk("mrst_vel", velocity, 32'd20);

      // window=0 acts as one cycle
      enable = 1'b0;
      window = 24'd0;
      tick();
      enable = 1'b1;
      tick();
      wait_valid(5, 1, 0, 0, n, got);
      chk("w0_period", 32'(n), 32'd1);
      chk("w0_vel", velocity, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/enc_velocity.md
ENC_VELOCITY -- requirements
Module: enc_velocity

Interface
REQ-001 SHALL have parameter STALL_WINDOWS, default 4, meaning consecutive zero-delta windows before stall is flagged (range 1..255).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port count  input  32  signed position from the quadrature decoder.
REQ-005 SHALL have port faultn  input  1  decoder fault flag, active-low.
REQ-006 SHALL have port enable  input  1  measurement enable.
REQ-007 SHALL have port window  input  24  sample window length in clk cycles.
REQ-008 SHALL have port clear_fault  input  1  single-cycle clear of fault_latched.
REQ-009 SHALL have port velocity  output  32  signed position delta of the last completed window.
REQ-010 SHALL have port vel_avg  output  32  signed mean of the last 4 window deltas.
REQ-011 SHALL have port vel_valid  output  1  one-cycle pulse when velocity/vel_avg update.
REQ-012 SHALL have port avg_full  output  1  high once 4 valid windows are in the history.
REQ-013 SHALL have port stalled  output  1  shaft stall indication.
REQ-014 SHALL have port fault_latched  output  1  sticky decoder-fault indication.

Function
REQ-015 SHALL implement FSM states IDLE and RUN; IDLE->RUN when enable=1, RUN->IDLE when enable=0 (takes priority over all RUN actions that cycle).
REQ-016 SHALL, on IDLE->RUN, capture last<=count and load timer<=W-1, where W = window, with window=0 treated as W=1.
REQ-017 SHALL in RUN decrement timer each cycle; on timer==0 ("expiry") compute delta = count - last modulo 2^32, set last<=count, reload timer<=W-1 using window sampled at that cycle.
REQ-018 SHALL ignore changes to window except at entry to RUN and at expiry.
REQ-019 SHALL, on a valid expiry, register velocity<=delta and assert vel_valid for exactly the following cycle (1-cycle latency from expiry).
REQ-020 SHALL keep a 4-entry delta history shifted on each valid expiry, sum in 34-bit signed, and register vel_avg = sum >>> 2 (arithmetic, floor) together with velocity.
REQ-021 SHALL count valid expiries saturating at 4 and drive avg_full=1 when it reaches 4; entries not yet filled read as 0.
REQ-022 SHALL mark a window invalid if faultn is sampled low on any cycle of it, including the expiry cycle; an invalid expiry updates last and reloads timer but produces no vel_valid and no history/stall update.
REQ-023 SHALL set fault_latched when faultn is sampled low, clear it only on clear_fault; simultaneous set and clear SHALL leave it set.
REQ-024 SHALL count consecutive valid expiries with delta==0 (saturating at 255) and set stalled when the count reaches STALL_WINDOWS; a valid nonzero delta SHALL clear the count and stalled at the same update.
REQ-025 SHALL, on RUN->IDLE, hold velocity, vel_avg, stalled, avg_full and fault_latched; clear history, fill count and stall count only at next IDLE->RUN.
REQ-026 SHALL keep fault_latched tracking faultn in IDLE as well as RUN.

Reset
REQ-027 SHALL on reset asynchronously force state=IDLE, timer=0, last=0, history=0, fill and stall counts=0.
REQ-028 SHALL on reset drive velocity=0, vel_avg=0, vel_valid=0, avg_full=0, stalled=0, fault_latched=0.
REQ-029 SHALL on reset asserted mid-window abandon the window with no vel_valid; after release, require enable=1 to begin a fresh window.

Verification
REQ-030 SHALL verify: reset pulse during RUN -> all outputs 0 within same cycle, no vel_valid afterwards until W cycles after re-entry to RUN.
REQ-031 SHALL verify: window=10, count +3 per cycle -> vel_valid every 10 cycles, velocity=30; after 4th pulse vel_avg=30, avg_full=1.
REQ-032 SHALL verify: count crosses 0x7FFFFFFF advancing 0x20 per window -> velocity=+32, never negative; count -5 per window -> velocity=-5, vel_avg=-5 after 4 windows.
REQ-033 SHALL verify: STALL_WINDOWS=4, constant count -> stalled=1 with 4th vel_valid; count +1 next window -> stalled=0 with next vel_valid.
REQ-034 SHALL verify: faultn low 1 cycle mid-window -> that window gives no vel_valid, history unchanged, fault_latched=1; clear_fault same cycle as faultn low -> stays 1; clear_fault alone -> 0.
REQ-035 SHALL verify: enable dropped on expiry cycle -> no vel_valid; window changed 10->20 mid-window -> current window 10 cycles, next 20.
